// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-sensor I2C engine arbiter.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic REQ_GSENSOR = 1'b0;
    localparam logic REQ_LSENSOR = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/i2c_sensor_arbiter_if.sv
// Requester and byte-engine signals of the sensor arbiter, bundled as one bus.
interface i2c_sensor_arbiter_if;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_rw;
    logic [13:0] req_dev;
    logic [15:0] req_reg;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        eng_start;
    logic        eng_rw;
    logic [6:0]  eng_dev;
    logic [7:0]  eng_reg;
    logic [7:0]  eng_wdata;
    logic        eng_busy;
    logic        eng_done;
    logic        eng_nack;
    logic [7:0]  eng_rdata;
    logic        owner;

    // The arbiter itself connects as the slave side.
    modport slave (
        input  req_valid, req_rw, req_dev, req_reg, req_wdata,
               eng_busy, eng_done, eng_nack, eng_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               eng_start, eng_rw, eng_dev, eng_reg, eng_wdata, owner
    );

    modport master (
        output req_valid, req_rw, req_dev, req_reg, req_wdata,
               eng_busy, eng_done, eng_nack, eng_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               eng_start, eng_rw, eng_dev, eng_reg, eng_wdata, owner
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: on a tie the requester not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant_onehot,
    output logic       grant_idx
);

    always_comb begin
        grant_idx = req[1];
        if (req == 2'b11) begin
            grant_idx = ~last;
        end
        grant_onehot = (req == 2'b00) ? 2'b00 : (grant_idx ? 2'b10 : 2'b01);
    end

endmodule

// File: rtl/i2c_sensor_arbiter.sv
// Shares one I2C byte engine between the G-sensor and light sensor, one transaction at a time.
module i2c_sensor_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic                  clk,
    input logic                  reset,
    i2c_sensor_arbiter_if.slave  bus
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic            last;
    logic            owner_q;
    logic [WD_W-1:0] wd;
    logic [1:0]      grant_onehot;
    logic            grant_idx;

    rr_arbiter2 u_rr (
        .req          (bus.req_valid),
        .last         (last),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    assign bus.owner = owner_q;

    // Strobes are decoded from state and gated by reset so they stay low during reset.
    always_comb begin
        bus.req_ready = 2'b00;
        bus.eng_start = 1'b0;
        bus.rsp_valid = 2'b00;
        if (!reset) begin
            case (state)
                ST_IDLE:  bus.req_ready = grant_onehot;
                ST_ISSUE: bus.eng_start = ~bus.eng_busy;
                ST_RESP:  bus.rsp_valid = (owner_q == REQ_LSENSOR) ? 2'b10 : 2'b01;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            last          <= REQ_LSENSOR;
            owner_q       <= REQ_GSENSOR;
            wd            <= '0;
            bus.rsp_data  <= 8'h00;
            bus.rsp_err   <= 1'b0;
            bus.eng_rw    <= 1'b0;
            bus.eng_dev   <= 7'h00;
            bus.eng_reg   <= 8'h00;
            bus.eng_wdata <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.req_valid) begin
                        owner_q       <= grant_idx;
                        bus.eng_rw    <= bus.req_rw[grant_idx];
                        bus.eng_dev   <= grant_idx ? bus.req_dev[13:7]    : bus.req_dev[6:0];
                        bus.eng_reg   <= grant_idx ? bus.req_reg[15:8]    : bus.req_reg[7:0];
                        bus.eng_wdata <= grant_idx ? bus.req_wdata[15:8]  : bus.req_wdata[7:0];
                        wd            <= '0;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // The eng_start cycle itself counts as watchdog cycle 0.
                    if (!bus.eng_busy) begin
                        wd    <= WD_W'(1);
                        state <= ST_WAIT;
                    end else begin
                        wd <= '0;
                    end
                end
                ST_WAIT: begin
                    if (bus.eng_done) begin
                        bus.rsp_data <= bus.eng_rdata;
                        bus.rsp_err  <= bus.eng_nack;
                        state        <= ST_RESP;
                    end else if (wd == WD_LAST) begin
                        bus.rsp_data <= 8'h00;
                        bus.rsp_err  <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_RESP: begin
                    last  <= owner_q;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_sensor_arbiter.sv
// Directed bench for i2c_sensor_arbiter with a 16-cycle watchdog.
module tb_i2c_sensor_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    i2c_sensor_arbiter_if bus();

    i2c_sensor_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.req_valid = 2'b00;
        bus.req_rw    = 2'b00;
        bus.req_dev   = 14'h0;
        bus.req_reg   = 16'h0;
        bus.req_wdata = 16'h0;
        bus.eng_busy  = 1'b0;
        bus.eng_done  = 1'b0;
        bus.eng_nack  = 1'b0;
        bus.eng_rdata = 8'h00;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        bus.req_valid = 2'b11;
        tick();
        tick();
        sample();
        checks++;
        if (bus.req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready);
        end
        checks++;
        if ({bus.rsp_valid, bus.eng_start} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 000", {bus.rsp_valid, bus.eng_start});
        end
        checks++;
        if ({bus.rsp_data, bus.rsp_err, bus.owner} !== 10'h000) begin
            errors++; $display("FAIL reset_rsp_owner: got %h expected 000", {bus.rsp_data, bus.rsp_err, bus.owner});
        end
        checks++;
        if ({bus.eng_rw, bus.eng_dev, bus.eng_reg, bus.eng_wdata} !== 24'h0) begin
            errors++; $display("FAIL reset_eng_fields: got %h expected 000000",
                               {bus.eng_rw, bus.eng_dev, bus.eng_reg, bus.eng_wdata});
        end
        tick();
        bus.req_valid = 2'b00;
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        tick();
        bus.req_valid = 2'b01;
        bus.req_rw    = 2'b01;
        bus.req_dev   = {7'h00, 7'h53};
        bus.req_reg   = {8'h00, 8'h32};
        sample();
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++; $display("FAIL single_req_ready: got %b expected 01", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        bus.req_dev   = 14'h0;
        sample();
        checks++;
        if (bus.eng_start !== 1'b1) begin
            errors++; $display("FAIL single_eng_start: got %b expected 1", bus.eng_start);
        end
        checks++;
        if ({bus.eng_rw, bus.eng_dev, bus.eng_reg} !== {1'b1, 7'h53, 8'h32}) begin
            errors++; $display("FAIL single_eng_fields: got rw=%b dev=%h reg=%h expected rw=1 dev=53 reg=32",
                               bus.eng_rw, bus.eng_dev, bus.eng_reg);
        end
        tick();
        sample();
        checks++;
        if (bus.eng_start !== 1'b0 || bus.eng_dev !== 7'h53) begin
            errors++; $display("FAIL single_start_once: got start=%b dev=%h expected start=0 dev=53",
                               bus.eng_start, bus.eng_dev);
        end
        bus.eng_done  = 1'b1;
        bus.eng_rdata = 8'hA5;
        bus.eng_nack  = 1'b0;
        tick();
        bus.eng_done  = 1'b0;
        bus.eng_rdata = 8'h00;
        sample();
        checks++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 8'hA5 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL single_rsp: got valid=%b data=%h err=%b expected valid=01 data=a5 err=0",
                               bus.rsp_valid, bus.rsp_data, bus.rsp_err);
        end
        tick();
        sample();
        checks++;
        if (bus.rsp_valid !== 2'b00 || bus.rsp_data !== 8'hA5) begin
            errors++; $display("FAIL single_rsp_hold: got valid=%b data=%h expected valid=00 data=a5",
                               bus.rsp_valid, bus.rsp_data);
        end
    endtask

    task automatic test_tie();
        int exp_idx [3] = '{0, 1, 0};
        apply_reset();
        bus.req_valid = 2'b11;
        bus.req_rw    = 2'b10;
        bus.req_dev   = {7'h29, 7'h53};
        bus.req_reg   = {8'h0C, 8'h32};
        bus.req_wdata = {8'h77, 8'h11};
        for (int i = 0; i < 3; i++) begin
            int n = 0;
            logic [1:0] exp_oh;
            exp_oh = (exp_idx[i] == 1) ? 2'b10 : 2'b01;
            sample();
            while (bus.req_ready === 2'b00 && n < 20) begin
                tick(); sample(); n++;
            end
            checks++;
            if (bus.req_ready !== exp_oh) begin
                errors++; $display("FAIL tie_grant%0d: got %b expected %b", i, bus.req_ready, exp_oh);
            end
            tick();
            sample();
            checks++;
            if (bus.eng_start !== 1'b1 || bus.owner !== exp_idx[i][0]
                || bus.eng_dev !== (exp_idx[i] == 1 ? 7'h29 : 7'h53)
                || bus.eng_wdata !== (exp_idx[i] == 1 ? 8'h77 : 8'h11)
                || bus.eng_rw !== exp_idx[i][0]) begin
                errors++; $display("FAIL tie_issue%0d: got start=%b owner=%b dev=%h wdata=%h rw=%b expected owner=%0d",
                                   i, bus.eng_start, bus.owner, bus.eng_dev, bus.eng_wdata, bus.eng_rw, exp_idx[i]);
            end
            tick();
            bus.eng_done  = 1'b1;
            bus.eng_rdata = 8'h10 + 8'(i);
            tick();
            bus.eng_done  = 1'b0;
            sample();
            checks++;
            if (bus.rsp_valid !== exp_oh || bus.owner !== exp_idx[i][0] || bus.rsp_data !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL tie_rsp%0d: got valid=%b owner=%b data=%h expected valid=%b data=%h",
                                   i, bus.rsp_valid, bus.owner, bus.rsp_data, exp_oh, 8'h10 + 8'(i));
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_busy();
        int early = 0;
        bus.eng_busy  = 1'b1;
        bus.req_valid = 2'b01;
        bus.req_dev   = {7'h00, 7'h1D};
        sample();
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++; $display("FAIL busy_req_ready: got %b expected 01", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (bus.eng_start === 1'b1) early++;
            tick();
        end
        bus.eng_busy = 1'b0;
        sample();
        checks++;
        if (early != 0 || bus.eng_start !== 1'b1) begin
            errors++; $display("FAIL busy_start: got early=%0d start=%b expected early=0 start=1", early, bus.eng_start);
        end
        tick();
        sample();
        checks++;
        if (bus.eng_start !== 1'b0) begin
            errors++; $display("FAIL busy_single_pulse: got %b expected 0", bus.eng_start);
        end
        bus.eng_done  = 1'b1;
        bus.eng_rdata = 8'h42;
        tick();
        bus.eng_done  = 1'b0;
        sample();
        checks++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 8'h42) begin
            errors++; $display("FAIL busy_rsp: got valid=%b data=%h expected valid=01 data=42", bus.rsp_valid, bus.rsp_data);
        end
        tick();
    endtask

    task automatic test_timeout();
        int k = 0;
        bus.req_valid = 2'b10;
        sample();
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++; $display("FAIL timeout_req_ready: got %b expected 10", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
        bus.eng_rdata = 8'h5A;
        sample();
        checks++;
        if (bus.eng_start !== 1'b1) begin
            errors++; $display("FAIL timeout_start: got %b expected 1", bus.eng_start);
        end
        do begin
            tick(); sample(); k++;
        end while (bus.rsp_valid === 2'b00 && k < 40);
        checks++;
        if (k != 16 || bus.rsp_valid !== 2'b10 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 8'h00) begin
            errors++; $display("FAIL timeout_rsp: got delay=%0d valid=%b err=%b data=%h expected delay=16 valid=10 err=1 data=00",
                               k, bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
        tick();
        bus.eng_done  = 1'b1;
        bus.eng_rdata = 8'hFF;
        tick();
        bus.eng_done  = 1'b0;
        sample();
        checks++;
        if (bus.rsp_valid !== 2'b00 || bus.eng_start !== 1'b0 || bus.rsp_data !== 8'h00 || bus.rsp_err !== 1'b1) begin
            errors++; $display("FAIL timeout_late_done: got valid=%b start=%b data=%h err=%b expected 00 0 00 1",
                               bus.rsp_valid, bus.eng_start, bus.rsp_data, bus.rsp_err);
        end
        tick();
    endtask

    task automatic test_collision();
        bus.req_valid = 2'b01;
        sample();
        tick();
        bus.req_valid = 2'b00;
        sample();
        checks++;
        if (bus.eng_start !== 1'b1) begin
            errors++; $display("FAIL collide_start: got %b expected 1", bus.eng_start);
        end
        for (int k = 0; k < 15; k++) tick();
        bus.eng_done  = 1'b1;
        bus.eng_nack  = 1'b1;
        bus.eng_rdata = 8'h3C;
        sample();
        checks++;
        if (bus.rsp_valid !== 2'b00) begin
            errors++; $display("FAIL collide_early_rsp: got %b expected 00", bus.rsp_valid);
        end
        tick();
        bus.eng_done = 1'b0;
        bus.eng_nack = 1'b0;
        sample();
        checks++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 8'h3C) begin
            errors++; $display("FAIL collide_rsp: got valid=%b err=%b data=%h expected valid=01 err=1 data=3c",
                               bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        int strobes = 0;
        bus.req_valid = 2'b01;
        bus.req_dev   = {7'h00, 7'h53};
        sample();
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        reset = 1'b1;
        sample();
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.eng_start} !== 5'b0) begin
            errors++; $display("FAIL rstwait_during: got %b expected 00000", {bus.req_ready, bus.rsp_valid, bus.eng_start});
        end
        tick();
        reset = 1'b0;
        bus.eng_done  = 1'b1;
        bus.eng_nack  = 1'b1;
        bus.eng_rdata = 8'hEE;
        tick();
        bus.eng_done = 1'b0;
        bus.eng_nack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            if (bus.rsp_valid !== 2'b00 || bus.eng_start !== 1'b0) strobes++;
            tick();
        end
        checks++;
        if (strobes != 0) begin
            errors++; $display("FAIL rstwait_strobes: got %0d strobe cycles expected 0", strobes);
        end
        checks++;
        if ({bus.rsp_data, bus.rsp_err, bus.owner, bus.eng_rw, bus.eng_dev, bus.eng_reg, bus.eng_wdata} !== 34'h0) begin
            errors++; $display("FAIL rstwait_outputs: got data=%h err=%b owner=%b dev=%h expected all 0",
                               bus.rsp_data, bus.rsp_err, bus.owner, bus.eng_dev);
        end
        bus.req_valid = 2'b11;
        sample();
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++; $display("FAIL rstwait_tie: got %b expected 01", bus.req_ready);
        end
        tick();
        bus.req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_busy();
        test_timeout();
        test_collision();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
